reg_scoreboard: RTL and testbench

Parametrised register scoreboard for the in-order pipelined CPU: it generalises the fixed load-use hazard check into per-register latency tracking. It supports arbitrary producer latencies: ALU, load, and future multi-cycle mul/div. It sits at the ID stage, where it compares the issuing instruction's sources and destination against pending writes. It raises a stall that drives the bubble path: PC hold, IF/ID hold, and control zeroed into ID/EX. It also keeps a saturating stall-cycle performance counter.

---
 rtl/reg_scoreboard_if.sv | 30 +++
 rtl/reg_scoreboard.sv | 43 ++++
 tb/tb_reg_scoreboard.sv | 129 ++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: ID-stage issue bundle and scoreboard status between the pipeline and reg_scoreboard.
interface reg_scoreboard_if #(
  parameter int ADDR_W = 5,
  parameter int LAT_W  = 3,
  parameter int CNT_W  = 16
);
  logic                 issue_valid_i;
  logic [ADDR_W-1:0]    issue_rs_i;
  logic                 issue_rs_used_i;
  logic [ADDR_W-1:0]    issue_rt_i;
  logic                 issue_rt_used_i;
  logic [ADDR_W-1:0]    issue_rd_i;
  logic                 issue_we_i;
  logic [LAT_W-1:0]     issue_lat_i;
  logic                 flush_i;
  logic                 stall_o;
  logic                 issue_accept_o;
  logic [2**ADDR_W-1:0] busy_o;
  logic [CNT_W-1:0]     stall_cnt_o;
  modport master (
    output issue_valid_i, issue_rs_i, issue_rs_used_i, issue_rt_i, issue_rt_used_i,
    output issue_rd_i, issue_we_i, issue_lat_i, flush_i,
    input  stall_o, issue_accept_o, busy_o, stall_cnt_o
  );
  modport slave (
    input  issue_valid_i, issue_rs_i, issue_rs_used_i, issue_rt_i, issue_rt_used_i,
    input  issue_rd_i, issue_we_i, issue_lat_i, flush_i,
    output stall_o, issue_accept_o, busy_o, stall_cnt_o
  );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register latency countdown raising ID-stage RAW/WAW stalls, with a saturating stall counter.
module reg_scoreboard #(
  parameter int ADDR_W       = 5,
  parameter int LAT_W        = 3,
  parameter int R0_HARDWIRED = 1,
  parameter int CNT_W        = 16
) (
  input logic             clk_i,
  input logic             rst_i,
  reg_scoreboard_if.slave sb
);
  localparam int NREG = 2**ADDR_W;
  logic [LAT_W-1:0] r_cnt [NREG];
  logic [CNT_W-1:0] r_stall_cnt;
  logic w_rs_haz, w_rt_haz, w_waw_haz, w_rd_trk, w_live, w_stall, w_load;
  always_comb begin
    w_rd_trk  = !(R0_HARDWIRED != 0 && sb.issue_rd_i == '0);
    w_rs_haz  = sb.issue_rs_used_i && !(R0_HARDWIRED != 0 && sb.issue_rs_i == '0) && r_cnt[sb.issue_rs_i] != '0;
    w_rt_haz  = sb.issue_rt_used_i && !(R0_HARDWIRED != 0 && sb.issue_rt_i == '0) && r_cnt[sb.issue_rt_i] != '0;
    w_waw_haz = sb.issue_we_i && w_rd_trk && r_cnt[sb.issue_rd_i] > sb.issue_lat_i;
    w_live    = sb.issue_valid_i && !sb.flush_i;
    w_stall   = w_live && (w_rs_haz || w_rt_haz || w_waw_haz);
    w_load    = w_live && !w_stall && sb.issue_we_i && w_rd_trk;
  end
  assign sb.stall_o        = w_stall;
  assign sb.issue_accept_o = w_live && !w_stall;
  assign sb.stall_cnt_o    = r_stall_cnt;
  for (genvar g = 0; g < NREG; g++) begin : g_busy
    assign sb.busy_o[g] = r_cnt[g] != '0;
  end
  // A new load wins over the entry's own decrement; r0 never loads when hardwired.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int r = 0; r < NREG; r++)
        if (w_load && sb.issue_rd_i == ADDR_W'(r)) r_cnt[r] <= sb.issue_lat_i;
        else if (r_cnt[r] != '0) r_cnt[r] <= r_cnt[r] - 1'b1;
      if (w_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed checks of hazards, r0, flush, async reset and counter saturation (CNT_W=4).
module tb_reg_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  always #5 clk = ~clk;
  reg_scoreboard_if #(.CNT_W(4)) sb ();
  reg_scoreboard #(.CNT_W(4)) dut (.clk_i(clk), .rst_i(rst), .sb(sb.slave));
  task automatic drive(input logic v, input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                       input logic rtu, input logic [4:0] rd, input logic we, input logic [2:0] lat,
                       input logic fl);
    sb.issue_valid_i = v;  sb.issue_rs_i = rs; sb.issue_rs_used_i = rsu;
    sb.issue_rt_i = rt;    sb.issue_rt_used_i = rtu; sb.issue_rd_i = rd;
    sb.issue_we_i = we;    sb.issue_lat_i = lat; sb.flush_i = fl;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    drive(1, 1, 0, 2, 0, 9, 0, 0, 0);
    chk("rst_stall", sb.stall_o, 0);
    chk("rst_accept", sb.issue_accept_o, 1);
    chk("rst_busy", sb.busy_o, 0);
    chk("rst_cnt", sb.stall_cnt_o, 0);
    #2 rst = 1'b0;
    tick();
    // load-use: lw r8 (lat 1) then add r9,r8,r8
    drive(1, 1, 1, 2, 0, 8, 1, 1, 0);
    chk("lw_accept", sb.issue_accept_o, 1);
    tick();
    chk("lw_busy", sb.busy_o, 32'h0000_0100);
    drive(1, 8, 1, 8, 1, 9, 1, 0, 0);
    chk("lu_stall", sb.stall_o, 1);
    chk("lu_noaccept", sb.issue_accept_o, 0);
    tick();
    chk("lu_stall2", sb.stall_o, 0);
    chk("lu_accept2", sb.issue_accept_o, 1);
    chk("lu_scnt", sb.stall_cnt_o, 1);
    tick();
    // back-to-back ALU
    drive(1, 1, 1, 2, 1, 3, 1, 0, 0);
    chk("alu1_accept", sb.issue_accept_o, 1);
    tick();
    chk("alu1_busy", sb.busy_o, 0);
    drive(1, 3, 1, 3, 1, 4, 1, 0, 0);
    chk("alu2_stall", sb.stall_o, 0);
    chk("alu2_accept", sb.issue_accept_o, 1);
    tick();
    chk("alu2_busy", sb.busy_o, 0);
    // multi-cycle then WAW on r5
    drive(1, 1, 1, 2, 1, 5, 1, 3, 0);
    chk("mul_accept", sb.issue_accept_o, 1);
    tick();
    chk("mul_busy", sb.busy_o, 32'h0000_0020);
    drive(1, 1, 1, 2, 1, 5, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("waw_stall", sb.stall_o, 1);
      chk("waw_noaccept", sb.issue_accept_o, 0);
      tick();
    end
    chk("waw_stall_end", sb.stall_o, 0);
    chk("waw_accept", sb.issue_accept_o, 1);
    chk("waw_scnt", sb.stall_cnt_o, 4);
    tick();
    chk("waw_busy", sb.busy_o, 0);
    // r0 hardwired
    drive(1, 1, 1, 2, 1, 0, 1, 3, 0);
    chk("r0w_accept", sb.issue_accept_o, 1);
    tick();
    chk("r0_busy", sb.busy_o, 0);
    drive(1, 0, 1, 0, 1, 12, 1, 0, 0);
    chk("r0r_stall", sb.stall_o, 0);
    tick();
    // unused source that is busy
    drive(1, 1, 1, 2, 1, 6, 1, 2, 0);
    tick();
    chk("r6_busy", sb.busy_o, 32'h0000_0040);
    drive(1, 1, 1, 6, 0, 13, 0, 0, 0);
    chk("rtunused_stall", sb.stall_o, 0);
    chk("rtunused_accept", sb.issue_accept_o, 1);
    drive(1, 6, 1, 6, 0, 13, 0, 0, 0);
    chk("rsused_stall", sb.stall_o, 1);
    drive(1, 1, 1, 6, 0, 13, 0, 0, 0);
    tick();
    // flush masks stall/accept and blocks load of r7
    drive(1, 6, 1, 2, 0, 7, 1, 3, 1);
    chk("fl_stall", sb.stall_o, 0);
    chk("fl_accept", sb.issue_accept_o, 0);
    tick();
    chk("fl_busy", sb.busy_o, 0);
    chk("fl_scnt", sb.stall_cnt_o, 4);
    // async reset mid-countdown
    drive(1, 1, 1, 2, 1, 10, 1, 3, 0);
    tick();
    drive(1, 10, 1, 2, 0, 14, 1, 0, 0);
    chk("pre_rst_stall", sb.stall_o, 1);
    tick();
    chk("pre_rst_scnt", sb.stall_cnt_o, 5);
    chk("pre_rst_busy", sb.busy_o, 32'h0000_0400);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", sb.busy_o, 0);
    chk("arst_scnt", sb.stall_cnt_o, 0);
    chk("arst_stall", sb.stall_o, 0);
    chk("arst_accept", sb.issue_accept_o, 1);
    rst = 1'b0;
    tick();
    // self-dependent lat-7 op: accept, 7 stalls, repeat -> saturates at 15
    drive(1, 11, 1, 2, 0, 11, 1, 7, 0);
    chk("self_accept", sb.issue_accept_o, 1);
    for (int i = 0; i < 16; i++) tick();
    chk("sat_mid", sb.stall_cnt_o, 14);
    for (int i = 0; i < 8; i++) tick();
    chk("sat_top", sb.stall_cnt_o, 15);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
